// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM that sequences the game datapath.
// It drives the 4-bit address counter (clear and count enable), loads the
// player-switch register and checks each play until success or error.
// Optional feature: define UNIDADE_CONTROLE_TIMEOUT_EN to build the ESPERA
// timeout counter. Without it, FIM_TIMEOUT is unreachable and TIMEOUT is 0.
module unidade_controle_jogo #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       INICIAR,
   input  logic       JOGADA,
   input  logic       IGUAL,
   input  logic       FIM,
   output logic       ZERA_N,
   output logic       CONTA,
   output logic       REGISTRA,
   output logic       PRONTO,
   output logic       ACERTOU,
   output logic       ERROU,
   output logic       TIMEOUT,
   output logic [3:0] DB_ESTADO
);

   // State codes double as the debug output, so they are fixed explicitly.
   typedef enum logic [3:0] {
      st_inicial     = 4'd0,
      st_prepara     = 4'd1,
      st_espera      = 4'd2,
      st_registra    = 4'd3,
      st_compara     = 4'd4,
      st_proximo     = 4'd5,
      st_fim_acerto  = 4'd6,
      st_fim_erro    = 4'd7,
      st_fim_timeout = 4'd8
   } estado_t;

   estado_t estado_q, estado_d;
   logic    jogada_q;
   logic    jogada_pulse;
   logic    tmr_fim;
   logic    timeout_dec;

   // Resets to 1 so a button held through reset is not seen as a fresh press.
   assign jogada_pulse = JOGADA & ~jogada_q;

   // Button history register for rising-edge detection.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         jogada_q <= 1'b1;
      end else begin
         jogada_q <= JOGADA;
      end
   end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   localparam int unsigned TmrW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [TmrW-1:0] tmr_q, tmr_d;

   // Counts cycles spent in ESPERA; held at zero everywhere else so each
   // entry into ESPERA starts a fresh window.
   always_comb begin
      tmr_d = '0;
      if (estado_q == st_espera) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

   // tmr_q holds the number of ESPERA cycles already completed, so the
   // terminal cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign tmr_fim = (estado_q == st_espera) && (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cycles;

   assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
   assign tmr_fim               = 1'b0;
`endif

   // State register; CLR drops the FSM to INICIAL immediately.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         estado_q <= st_inicial;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next-state logic. A press in the terminal timeout cycle still wins.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         st_inicial: begin
            if (INICIAR) begin
               estado_d = st_prepara;
            end
         end
         st_prepara: begin
            estado_d = st_espera;
         end
         st_espera: begin
            if (jogada_pulse) begin
               estado_d = st_registra;
            end else if (tmr_fim) begin
               estado_d = st_fim_timeout;
            end
         end
         st_registra: begin
            estado_d = st_compara;
         end
         st_compara: begin
            // A mismatch ends the game even at the last address.
            if (!IGUAL) begin
               estado_d = st_fim_erro;
            end else if (FIM) begin
               estado_d = st_fim_acerto;
            end else begin
               estado_d = st_proximo;
            end
         end
         st_proximo: begin
            estado_d = st_espera;
         end
         st_fim_acerto, st_fim_erro, st_fim_timeout: begin
            if (INICIAR) begin
               estado_d = st_prepara;
            end
         end
         default: begin
            estado_d = st_inicial;
         end
      endcase
   end

   // Moore output decode from the state register only.
   always_comb begin
      ZERA_N      = 1'b1;
      CONTA       = 1'b0;
      REGISTRA    = 1'b0;
      PRONTO      = 1'b0;
      ACERTOU     = 1'b0;
      ERROU       = 1'b0;
      timeout_dec = 1'b0;
      case (estado_q)
         st_prepara: begin
            ZERA_N = 1'b0;
         end
         st_registra: begin
            REGISTRA = 1'b1;
         end
         st_proximo: begin
            // Counter advances on the edge that ends this state.
            CONTA = 1'b1;
         end
         st_fim_acerto: begin
            PRONTO  = 1'b1;
            ACERTOU = 1'b1;
         end
         st_fim_erro: begin
            PRONTO = 1'b1;
            ERROU  = 1'b1;
         end
         st_fim_timeout: begin
            PRONTO      = 1'b1;
            timeout_dec = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   assign TIMEOUT = timeout_dec;
`else
   logic unused_timeout_dec;

   assign unused_timeout_dec = timeout_dec;
   assign TIMEOUT            = 1'b0;
`endif

   assign DB_ESTADO = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo. Expected state/output
// vectors are queued when stimulus is driven and checked after the edge.
module tb_unidade_controle_jogo;

   localparam int unsigned TCYC = 8;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic       INICIAR = 1'b0;
   logic       JOGADA = 1'b0;
   logic       IGUAL = 1'b0;
   logic       FIM = 1'b0;
   logic       ZERA_N, CONTA, REGISTRA, PRONTO, ACERTOU, ERROU, TIMEOUT;
   logic [3:0] DB_ESTADO;

   typedef struct {
      string       tag;
      logic [10:0] v;
   } sb_entry_t;

   sb_entry_t sb[$];
   int        n_cmp = 0;
   int        n_err = 0;
   int        n_conta = 0;
   int        n_reg = 0;

   unidade_controle_jogo #(.TIMEOUT_CYCLES(TCYC)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .INICIAR   (INICIAR),
      .JOGADA    (JOGADA),
      .IGUAL     (IGUAL),
      .FIM       (FIM),
      .ZERA_N    (ZERA_N),
      .CONTA     (CONTA),
      .REGISTRA  (REGISTRA),
      .PRONTO    (PRONTO),
      .ACERTOU   (ACERTOU),
      .ERROU     (ERROU),
      .TIMEOUT   (TIMEOUT),
      .DB_ESTADO (DB_ESTADO)
   );

   always #5 CLK = ~CLK;

   // Pulse tallies, sampled mid-cycle.
   always @(negedge CLK) begin
      if (CONTA === 1'b1) n_conta <= n_conta + 1;
      if (REGISTRA === 1'b1) n_reg <= n_reg + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // Expected {ZERA_N,CONTA,REGISTRA,PRONTO,ACERTOU,ERROU,TIMEOUT,DB_ESTADO}.
   function automatic logic [10:0] exp_out(input logic [3:0] s);
      logic zn, co, rg, pr, ac, er, to;
      zn = 1'b1; co = 1'b0; rg = 1'b0; pr = 1'b0; ac = 1'b0; er = 1'b0; to = 1'b0;
      case (s)
         4'd1: zn = 1'b0;
         4'd3: rg = 1'b1;
         4'd5: co = 1'b1;
         4'd6: begin pr = 1'b1; ac = 1'b1; end
         4'd7: begin pr = 1'b1; er = 1'b1; end
         4'd8: begin pr = 1'b1; to = 1'b1; end
         default: ;
      endcase
      return {zn, co, rg, pr, ac, er, to, s};
   endfunction

   task automatic push_exp(input string tag, input logic [3:0] st);
      sb_entry_t e;
      e.tag = tag;
      e.v   = exp_out(st);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      sb_entry_t e;
      if (sb.size() == 0) begin
         check_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq(e.tag, {21'd0, ZERA_N, CONTA, REGISTRA, PRONTO, ACERTOU, ERROU, TIMEOUT,
                          DB_ESTADO}, {21'd0, e.v});
      end
   endtask

   // One clock: drive inputs, queue the expected post-edge state, then check.
   task automatic cyc(input string tag, input logic ini, input logic jog, input logic ig,
                      input logic fim, input logic [3:0] st);
      INICIAR = ini;
      JOGADA  = jog;
      IGUAL   = ig;
      FIM     = fim;
      push_exp(tag, st);
      @(posedge CLK);
      #1;
      pop_check();
   endtask

   // One play starting in ESPERA with JOGADA low in the previous cycle.
   task automatic play(input string tag, input logic ig, input logic fim);
      cyc({tag, ".reg"}, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      cyc({tag, ".cmp"}, 1'b0, 1'b0, ig, fim, 4'd4);
      cyc({tag, ".res"}, 1'b0, 1'b0, ig, fim, ig ? (fim ? 4'd6 : 4'd5) : 4'd7);
      if (ig && !fim) cyc({tag, ".esp"}, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_c, base_r;

      // Reset state while CLR is held low.
      #3;
      push_exp("reset", 4'd0);
      #1;
      pop_check();
      @(posedge CLK);
      #1;
      CLR = 1'b1;

      // Test 1: start sequence.
      cyc("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cyc("t1.prep", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      cyc("t1.esp",  1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

      // Test 2: full correct game, FIM only on the 16th compare.
      base_c = n_conta;
      base_r = n_reg;
      for (int i = 0; i < 16; i++) play($sformatf("t2.p%0d", i), 1'b1, i == 15);
      cyc("t2.hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
      #4;
      check_eq("t2.n_conta", n_conta - base_c, 15);
      check_eq("t2.n_reg", n_reg - base_r, 16);

      // Test 3: restart, error on third play, restart again.
      cyc("t3.prep", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      cyc("t3.esp",  1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      base_c = n_conta;
      play("t3.p0", 1'b1, 1'b0);
      play("t3.p1", 1'b1, 1'b0);
      play("t3.p2", 1'b0, 1'b1);
      cyc("t3.hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
      #4;
      check_eq("t3.n_conta", n_conta - base_c, 2);
      cyc("t3.reprep", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      cyc("t3.reesp",  1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

      // Test 4: JOGADA held 10 cycles with INICIAR high -> one play only.
      base_r = n_reg;
      cyc("t4.h0", 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      cyc("t4.h1", 1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
      cyc("t4.h2", 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
      cyc("t4.h3", 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
      for (int i = 4; i < 10; i++) cyc($sformatf("t4.h%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
      cyc("t4.rel", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      #4;
      check_eq("t4.n_reg", n_reg - base_r, 1);

      // Test 5: asynchronous clear in PROXIMO, JOGADA held across release.
      cyc("t5.reg", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      cyc("t5.cmp", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
      cyc("t5.prx", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      #2;
      CLR    = 1'b0;
      JOGADA = 1'b1;
      push_exp("t5.async", 4'd0);
      #1;
      pop_check();
      push_exp("t5.inrst", 4'd0);
      @(posedge CLK);
      #1;
      pop_check();
      CLR = 1'b1;
      base_r = n_reg;
      cyc("t5.prep",  1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      cyc("t5.esp",   1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      cyc("t5.held",  1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      cyc("t5.low",   1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      #4;
      check_eq("t5.no_reg", n_reg - base_r, 0);
      cyc("t5.press", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      cyc("t5.cmp2",  1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
      cyc("t5.prx2",  1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      cyc("t5.esp2",  1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

      // Test 6: timeout window (only expires when the feature is built).
      for (int i = 1; i < TCYC; i++) cyc($sformatf("t6.w%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      cyc("t6.late_press", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      cyc("t6.cmp", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
      cyc("t6.prx", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      cyc("t6.esp", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
      for (int i = 1; i < TCYC; i++) cyc($sformatf("t6.x%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      cyc("t6.tmo",  1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
      cyc("t6.hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
      cyc("t6.prep", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
`else
      for (int i = 0; i < 6; i++) cyc($sformatf("t6.nt%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
`endif

      check_eq("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
